difference_decoder: RTL and testbench
=====================================

# difference_decoder

Read-side counterpart of the encoded difference memory. On a start pulse it scans all eight entries, fetching each stored magnitude `|number − mask[index]|` plus its sign bit. It rebuilds the original number from the fixed mask table and streams `(index, number)` pairs out over a valid/ready handshake. It sits between the encoded memory's read port and any downstream consumer.

## Interface
Parameters:
- `DEPTH`, 8: number of entries scanned; fixed to match the 3-bit index space.
- `WIDTH`, 8: data width of stored magnitude and reconstructed number.

Ports:
- `CLK`  in  1  single clock, rising edge.
- `RST_N`  in  1  reset, asynchronous, active-low.
- `start`  in  1  one-cycle request to begin a scan; ignored while `busy`.
- `memRead`  out  1  read strobe to encoded memory.
- `memAddr`  out  3  entry index being read.
- `memData`  in  8  stored magnitude, valid one cycle after `memRead`.
- `memSign`  in  1  stored sign, valid with `memData`: 0 = number ≥ mask, 1 = number < mask.
- `outValid`  out  1  reconstructed pair available.
- `outReady`  in  1  consumer accepts when high with `outValid`.
- `outIndex`  out  3  index of the current output.
- `outNumber`  out  8  reconstructed number.
- `busy`  out  1  scan in progress.
- `done`  out  1  one-cycle pulse after the last entry is accepted.
- `err`  out  1  sticky flag for inconsistent data; cleared by the next accepted `start`.

## Operation
- Mask table, by index 0..7: 0x00, 0x55, 0xAA, 0x33, 0xCC, 0x0F, 0xF0, 0xFF.
- FSM states: IDLE, ISSUE, CAPTURE, OUTPUT, FINISH.
- IDLE → ISSUE on `start`:
  - clear entry counter to 0;
  - clear `err`;
  - raise `busy`.
- ISSUE:
  - `memRead`=1 and `memAddr`=counter for exactly one cycle;
  - → CAPTURE.
- CAPTURE:
  - register `memData` and `memSign`;
  - compute the reconstructed number;
  - → OUTPUT.
- OUTPUT:
  - `outValid`=1; `outIndex` and `outNumber` are held stable until the handshake.
  - On `outValid && outReady`: if counter = 7, → FINISH; otherwise increment the counter and → ISSUE.
- FINISH:
  - `done`=1 for one cycle;
  - `busy`=0;
  - → IDLE.
- Reconstruction is done in 9 bits:
  - sign=0: sum = mask + diff. If sum > 255, output 0xFF and set `err`.
  - sign=1: if diff > mask, output 0x00 and set `err`; otherwise output mask − diff.
- `start` asserted while `busy`: ignored, with no restart and no counter change.
- `start` asserted in the FINISH cycle: ignored. The earliest accepted start is in IDLE.
- `outReady` held high permanently: no stall, the scan runs at full rate.
- `outReady` low: stall in OUTPUT indefinitely. No further `memRead` is issued during the stall.

## Timing
- Reset values:
  - state IDLE;
  - `memRead`=0, `memAddr`=0;
  - `outValid`=0, `outIndex`=0, `outNumber`=0x00;
  - `busy`=0, `done`=0, `err`=0.
- Reset is asynchronous at any point, including mid-scan. It aborts the scan immediately, drops all outputs to the reset values, and loses any partially scanned data.
- Latency:
  - `start` sampled at edge N → `memRead` high during cycle N+1;
  - data is captured at edge N+2;
  - `outValid` is high from cycle N+3.
- Per entry the minimum cost is 3 cycles: ISSUE, CAPTURE, OUTPUT.
- A full scan takes a minimum of 24 cycles plus 1 FINISH cycle.
- `done` is high in the cycle after the 8th handshake.
- All outputs are registered. There is no combinational path from `outReady` to `memRead` or `memAddr`.

## Structure
- Shared package `diff_mem_pkg` holds:
  - `DEPTH` and `WIDTH`;
  - the FSM state enum;
  - the eight mask constants, so the encoder and decoder share a single source of truth.
- Sub-module `mask_rom`: combinational 3-bit → 8-bit lookup of the mask table.
- The FSM, counter and reconstruction datapath are implemented in the top module.

## Test plan
- Reset mid-scan:
  - stimulus: assert `RST_N`=0 while in OUTPUT with index 3;
  - response: `outValid`, `busy` and `err` drop to 0 immediately; a fresh `start` rescans from index 0.
- Nominal scan, `outReady`=1, all memory entries diff=0x00 sign=0:
  - outputs are index 0..7 → 0x00, 0x55, 0xAA, 0x33, 0xCC, 0x0F, 0xF0, 0xFF;
  - `done` pulses 25 cycles after `start`;
  - `err`=0.
- Mixed signs:
  - stimulus: index 1 has diff 0x0A sign 0; index 2 has diff 0x10 sign 1;
  - response: index 1 outputs 0x5F; index 2 outputs 0x9A.
- Error cases:
  - index 7 with diff 0x01 sign 0 → output 0xFF, `err`=1;
  - index 0 with diff 0x05 sign 1 → output 0x00, `err` stays 1 until the next start.
- Backpressure:
  - stimulus: hold `outReady`=0 for 5 cycles on index 4;
  - response: `outNumber`, `outIndex` and `outValid` stay stable; `memRead` stays 0; the scan resumes on ready.
- Stray start:
  - stimulus: pulse `start` during index 5;
  - response: no restart; the output sequence is unchanged; exactly one `done` pulse.

Source files
------------

// File: rtl/diff_mem_pkg.sv
// -----------------------------------------------------------------------------
// diff_mem_pkg
// Shared definitions for the encoded difference memory and its decoder:
// table depth and data width, the decoder FSM state type and the eight
// fixed mask constants. The encoder and decoder both read this package so
// that the mask table has exactly one definition.
// -----------------------------------------------------------------------------
package diff_mem_pkg;

  localparam int DEPTH = 8;
  localparam int WIDTH = 8;
  localparam int IDX_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_CAPTURE,
    ST_OUTPUT,
    ST_FINISH
  } state_t;

  // Element [i] is the mask of entry i (the rightmost literal is entry 0).
  localparam logic [DEPTH-1:0][WIDTH-1:0] MASK_TABLE = {
    8'hFF, 8'hF0, 8'h0F, 8'hCC, 8'h33, 8'hAA, 8'h55, 8'h00
  };

endpackage

// File: rtl/difference_decoder_if.sv
// -----------------------------------------------------------------------------
// difference_decoder_if
// Groups the encoded-memory read port and the (index, number) output stream.
//   memRead/memAddr   : read strobe and entry index (decoder -> memory)
//   memData/memSign   : stored magnitude and sign, one cycle after memRead
//   outValid/outReady : output handshake
//   outIndex/outNumber: current reconstructed pair
// master = decoder side, slave = memory plus downstream consumer side.
// -----------------------------------------------------------------------------
interface difference_decoder_if;
  import diff_mem_pkg::*;

  logic             memRead;
  logic [IDX_W-1:0] memAddr;
  logic [WIDTH-1:0] memData;
  logic             memSign;
  logic             outValid;
  logic             outReady;
  logic [IDX_W-1:0] outIndex;
  logic [WIDTH-1:0] outNumber;

  modport master (
    output memRead, memAddr, outValid, outIndex, outNumber,
    input  memData, memSign, outReady
  );

  modport slave (
    input  memRead, memAddr, outValid, outIndex, outNumber,
    output memData, memSign, outReady
  );

endinterface

// File: rtl/mask_rom.sv
// -----------------------------------------------------------------------------
// mask_rom
// Combinational lookup of the fixed mask table.
//   index : entry index (3 bits)
//   mask  : mask constant for that entry (8 bits)
// -----------------------------------------------------------------------------
module mask_rom
  import diff_mem_pkg::*;
(
  input  logic [IDX_W-1:0] index,
  output logic [WIDTH-1:0] mask
);

  assign mask = MASK_TABLE[index];

endmodule

// File: rtl/difference_decoder.sv
// -----------------------------------------------------------------------------
// difference_decoder
// Scans all eight entries of the encoded difference memory on a start pulse,
// rebuilds each number from its stored magnitude, sign and the fixed mask,
// and streams (index, number) pairs over a valid/ready handshake.
//   CLK, RST_N : clock (rising edge), asynchronous active-low reset
//   start      : one-cycle scan request, honoured only when idle
//   bus        : memory read port and output stream (master side)
//   busy       : scan in progress
//   done       : one-cycle pulse after the last pair is accepted
//   err        : sticky inconsistent-data flag, cleared by an accepted start
// -----------------------------------------------------------------------------
module difference_decoder
  import diff_mem_pkg::*;
(
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 start,
  difference_decoder_if.master bus,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  state_t           state;
  logic [IDX_W-1:0] count;
  logic [WIDTH-1:0] mask;
  logic [WIDTH:0]   recon;

  // Returns {error, number}. Out-of-range results clamp to the nearest rail
  // and raise the error bit; the sum is formed one bit wider to see overflow.
  function automatic logic [WIDTH:0] rebuild(input logic [WIDTH-1:0] m,
                                             input logic [WIDTH-1:0] d,
                                             input logic             s);
    logic [WIDTH:0] sum;
    sum = {1'b0, m} + {1'b0, d};
    if (!s) begin
      if (sum[WIDTH]) return {1'b1, {WIDTH{1'b1}}};
      return {1'b0, sum[WIDTH-1:0]};
    end
    if (d > m) return {1'b1, {WIDTH{1'b0}}};
    return {1'b0, m - d};
  endfunction

  // count equals memAddr while the read is outstanding, so the mask lines up
  // with the returned data in CAPTURE.
  mask_rom u_mask_rom (
    .index (count),
    .mask  (mask)
  );

  assign recon = rebuild(mask, bus.memData, bus.memSign);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state         <= ST_IDLE;
      count         <= '0;
      bus.memRead   <= 1'b0;
      bus.memAddr   <= '0;
      bus.outValid  <= 1'b0;
      bus.outIndex  <= '0;
      bus.outNumber <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            count       <= '0;
            err         <= 1'b0;
            busy        <= 1'b1;
            bus.memRead <= 1'b1;
            bus.memAddr <= '0;
            state       <= ST_ISSUE;
          end
        end
        // read strobe is up for exactly this one cycle
        ST_ISSUE: begin
          bus.memRead <= 1'b0;
          state       <= ST_CAPTURE;
        end
        // memory data is valid now; register the rebuilt pair
        ST_CAPTURE: begin
          bus.outNumber <= recon[WIDTH-1:0];
          bus.outIndex  <= count;
          bus.outValid  <= 1'b1;
          if (recon[WIDTH]) err <= 1'b1;
          state <= ST_OUTPUT;
        end
        // hold the pair until accepted; the next read is issued only after
        // the handshake, so a stall never produces a memRead
        ST_OUTPUT: begin
          if (bus.outReady) begin
            bus.outValid <= 1'b0;
            if (count == IDX_W'(DEPTH - 1)) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= ST_FINISH;
            end else begin
              count       <= count + 1'b1;
              bus.memRead <= 1'b1;
              bus.memAddr <= count + 1'b1;
              state       <= ST_ISSUE;
            end
          end
        end
        ST_FINISH: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_difference_decoder.sv
// -----------------------------------------------------------------------------
// tb_difference_decoder
// Randomized and directed scans of difference_decoder against a behavioural
// model of the reconstruction rules, plus literal expectations.
// -----------------------------------------------------------------------------
module tb_difference_decoder;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic busy, done, err;

  difference_decoder_if ifc ();

  difference_decoder dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .start (start),
    .bus   (ifc),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  always #5 clk = ~clk;

  localparam int MASKS [8] = '{'h00, 'h55, 'hAA, 'h33, 'hCC, 'h0F, 'hF0, 'hFF};

  int  mem_diff [8];
  bit  mem_sign [8];
  int  got_num  [8];
  int  ptr;
  int  checks = 0;
  int  errors = 0;
  bit  prev_stall;
  int  prev_idx, prev_num;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reconstruction rules in plain integer arithmetic.
  function automatic void ref_entry(input int idx, output int num, output bit e);
    int m, d;
    m = MASKS[idx];
    d = mem_diff[idx];
    e = 1'b0;
    if (!mem_sign[idx]) begin
      num = m + d;
      if (num > 255) begin num = 255; e = 1'b1; end
    end else if (d > m) begin
      num = 0; e = 1'b1;
    end else begin
      num = m - d;
    end
  endfunction

  function automatic bit model_err();
    int n; bit e; bit any;
    any = 1'b0;
    for (int i = 0; i < 8; i++) begin
      ref_entry(i, n, e);
      any |= e;
    end
    return any;
  endfunction

  // Encoded memory: data appears one cycle after the read strobe; garbage
  // otherwise, so a capture in the wrong cycle shows up.
  always @(posedge clk) begin
    if (ifc.memRead === 1'b1) begin
      automatic int a = int'(ifc.memAddr);
      #1;
      ifc.memData = 8'(mem_diff[a]);
      ifc.memSign = mem_sign[a];
    end else begin
      #1;
      ifc.memData = 8'($urandom);
      ifc.memSign = 1'($urandom);
    end
  end

  // Output compare against the model on every valid cycle.
  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", int'(ifc.outValid), 1);
        chk("stall_index", int'(ifc.outIndex), prev_idx);
        chk("stall_number", int'(ifc.outNumber), prev_num);
      end
      if (ifc.outValid === 1'b1) begin
        if (ptr > 7) begin
          chk("extra_output", ptr, 7);
        end else begin
          int n; bit e;
          ref_entry(ptr, n, e);
          chk("out_index", int'(ifc.outIndex), ptr);
          chk("out_number", int'(ifc.outNumber), n);
          chk("no_read_in_output", int'(ifc.memRead), 0);
          got_num[ptr] = int'(ifc.outNumber);
          if (ifc.outReady === 1'b1) ptr++;
        end
      end
      prev_stall = (ifc.outValid === 1'b1) && (ifc.outReady !== 1'b1);
      prev_idx   = int'(ifc.outIndex);
      prev_num   = int'(ifc.outNumber);
    end
  end

  task automatic run_scan(input int ready_pct, input int stall_idx,
                          input int stray_idx, output int done_cyc);
    int  cyc, stall_left, extra;
    bit  seen, stray_done;
    @(posedge clk); #1;
    ptr = 0;
    start = 1'b1;
    ifc.outReady = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    chk("start_busy", int'(busy), 1);
    chk("start_memread", int'(ifc.memRead), 1);
    chk("start_memaddr", int'(ifc.memAddr), 0);
    chk("start_err_clear", int'(err), 0);
    seen = 1'b0; stray_done = 1'b0; stall_left = -1; done_cyc = -1;
    while (!seen && cyc < 400) begin
      start = 1'b0;
      if (stall_left < 0 && ifc.outValid && int'(ifc.outIndex) == stall_idx)
        stall_left = 5;
      if (stall_left > 0) begin
        ifc.outReady = 1'b0;
        stall_left--;
      end else begin
        ifc.outReady = ($urandom_range(99) < ready_pct);
      end
      if (!stray_done && ifc.outValid && int'(ifc.outIndex) == stray_idx) begin
        start = 1'b1;
        stray_done = 1'b1;
      end
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1'b1;
        done_cyc = cyc;
        chk("done_busy_low", int'(busy), 0);
        chk("done_err", int'(err), int'(model_err()));
        chk("done_count", ptr, 8);
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    ifc.outReady = 1'b1;
    if (!seen) chk("scan_timeout", cyc, -1);
    extra = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done === 1'b1) extra++;
    end
    chk("single_done", extra, 0);
  endtask

  initial begin
    int dc, guard;
    start = 1'b0;
    ifc.outReady = 1'b1;
    ifc.memData = '0;
    ifc.memSign = 1'b0;
    ptr = 0;
    prev_stall = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_memread", int'(ifc.memRead), 0);
    chk("rst_memaddr", int'(ifc.memAddr), 0);
    chk("rst_outvalid", int'(ifc.outValid), 0);
    chk("rst_outindex", int'(ifc.outIndex), 0);
    chk("rst_outnumber", int'(ifc.outNumber), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    @(negedge clk); rst_n = 1'b1;

    // Nominal: all-zero differences return the mask table itself.
    for (int i = 0; i < 8; i++) begin mem_diff[i] = 0; mem_sign[i] = 0; end
    run_scan(100, -1, -1, dc);
    chk("nominal_done_cycle", dc, 25);
    chk("nominal_err", int'(err), 0);
    for (int i = 0; i < 8; i++) chk($sformatf("nominal_num%0d", i), got_num[i], MASKS[i]);

    // Mixed signs.
    mem_diff[1] = 'h0A; mem_sign[1] = 0;
    mem_diff[2] = 'h10; mem_sign[2] = 1;
    run_scan(100, -1, -1, dc);
    chk("mixed_idx1", got_num[1], 'h5F);
    chk("mixed_idx2", got_num[2], 'h9A);

    // Error clamps.
    for (int i = 0; i < 8; i++) begin mem_diff[i] = 0; mem_sign[i] = 0; end
    mem_diff[7] = 'h01; mem_sign[7] = 0;
    mem_diff[0] = 'h05; mem_sign[0] = 1;
    run_scan(100, -1, -1, dc);
    chk("err_idx7", got_num[7], 'hFF);
    chk("err_idx0", got_num[0], 'h00);
    chk("err_sticky", int'(err), 1);

    // Backpressure on index 4 (start of this scan must clear err).
    for (int i = 0; i < 8; i++) begin mem_diff[i] = $urandom_range(15); mem_sign[i] = 1'($urandom); end
    run_scan(100, 4, -1, dc);
    chk("stall_done_cycle", dc, 30);

    // Stray start during index 5.
    run_scan(100, -1, 5, dc);
    chk("stray_done_cycle", dc, 25);

    // Random scans with random backpressure.
    for (int s = 0; s < 15; s++) begin
      for (int i = 0; i < 8; i++) begin
        mem_diff[i] = ($urandom_range(3) == 0) ? $urandom_range(255) : $urandom_range(15);
        mem_sign[i] = 1'($urandom);
      end
      run_scan(60, -1, -1, dc);
    end

    // Reset mid-scan while stalled on index 3.
    for (int i = 0; i < 8; i++) begin mem_diff[i] = 0; mem_sign[i] = 0; end
    mem_diff[0] = 'h05; mem_sign[0] = 1;
    @(posedge clk); #1;
    ptr = 0;
    start = 1'b1;
    ifc.outReady = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    guard = 0;
    while (!(ifc.outValid === 1'b1 && ifc.outIndex == 3'd3) && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    ifc.outReady = 1'b0;
    chk("reach_index3", int'(guard < 100), 1);
    chk("err_before_reset", int'(err), 1);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_outvalid", int'(ifc.outValid), 0);
    chk("async_rst_busy", int'(busy), 0);
    chk("async_rst_err", int'(err), 0);
    chk("async_rst_memread", int'(ifc.memRead), 0);
    chk("async_rst_outnumber", int'(ifc.outNumber), 0);
    @(negedge clk); #2;
    rst_n = 1'b1;
    ifc.outReady = 1'b1;
    run_scan(100, -1, -1, dc);
    chk("rescan_done_cycle", dc, 25);
    chk("rescan_idx0", got_num[0], 'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
